// File: rtl/lza_dt_seq_ctrl.sv
// Sequencer that streams an n/z/p position-string triple MSB-chunk-first through a
// detection-tree node and folds the per-chunk Z/P/N/Y flags. Optional macro: LZA_EARLY_EXIT_EN.
module lza_dt_seq_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_n_pos,
    input  logic [DATA_WIDTH-1:0]  in_z_pos,
    input  logic [DATA_WIDTH-1:0]  in_p_pos,
    output logic                   chunk_valid,
    output logic [CHUNK_WIDTH-1:0] chunk_n_pos,
    output logic [CHUNK_WIDTH-1:0] chunk_z_pos,
    output logic [CHUNK_WIDTH-1:0] chunk_p_pos,
    input  logic                   tree_Z,
    input  logic                   tree_P,
    input  logic                   tree_N,
    input  logic                   tree_Y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_Z,
    output logic                   out_P,
    output logic                   out_N,
    output logic                   out_Y
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_n_sh, r_z_sh, r_p_sh;
    logic                  r_acc_z, r_acc_p, r_acc_n, r_acc_y;
    logic                  r_in_ready, r_chunk_valid, r_out_valid;

    logic w_m_z, w_m_p, w_m_n, w_m_y;
    logic w_stop_early, w_last;

    // Accumulator is the more-significant half, the incoming chunk the less-significant half.
    assign w_m_z = r_acc_z & tree_Z;
    assign w_m_p = (r_acc_z & tree_P) | (r_acc_p & tree_Z);
    assign w_m_n = r_acc_n | (r_acc_z & tree_N);
    assign w_m_y = r_acc_y | (r_acc_z & tree_Y) | (r_acc_p & tree_N);

`ifdef LZA_EARLY_EXIT_EN
    // Once Z and P are both clear no later chunk can change the result.
    assign w_stop_early = ~w_m_z & ~w_m_p;
`else
    assign w_stop_early = 1'b0;
`endif
    assign w_last = (r_cnt == LAST_CNT) | w_stop_early;

    // NOTE: every register is updated with non-blocking assignments so all of them
    // sample pre-edge values; the async reset branch must list every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_n_sh        <= '0;
            r_z_sh        <= '0;
            r_p_sh        <= '0;
            r_acc_z       <= 1'b0;
            r_acc_p       <= 1'b0;
            r_acc_n       <= 1'b0;
            r_acc_y       <= 1'b0;
            r_in_ready    <= 1'b1;
            r_chunk_valid <= 1'b0;
            r_out_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_n_sh        <= in_n_pos;
                        r_z_sh        <= in_z_pos;
                        r_p_sh        <= in_p_pos;
                        r_acc_z       <= 1'b1;
                        r_acc_p       <= 1'b0;
                        r_acc_n       <= 1'b0;
                        r_acc_y       <= 1'b0;
                        r_cnt         <= '0;
                        r_in_ready    <= 1'b0;
                        r_chunk_valid <= 1'b1;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc_z <= w_m_z;
                    r_acc_p <= w_m_p;
                    r_acc_n <= w_m_n;
                    r_acc_y <= w_m_y;
                    r_n_sh  <= r_n_sh << CHUNK_WIDTH;
                    r_z_sh  <= r_z_sh << CHUNK_WIDTH;
                    r_p_sh  <= r_p_sh << CHUNK_WIDTH;
                    if (!w_stop_early) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_last) begin
                        r_chunk_valid <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_in_ready    <= 1'b1;
                    r_chunk_valid <= 1'b0;
                    r_out_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign chunk_valid = r_chunk_valid;
    assign chunk_n_pos = r_n_sh[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign chunk_z_pos = r_z_sh[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign chunk_p_pos = r_p_sh[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign out_valid   = r_out_valid;
    assign out_Z       = r_acc_z;
    assign out_P       = r_acc_p;
    assign out_N       = r_acc_n;
    assign out_Y       = r_acc_y;

endmodule

// File: tb/tb_lza_dt_seq_ctrl.sv
// Directed bench for lza_dt_seq_ctrl (32-bit strings, 8-bit chunks) with a behavioural
// 8-bit detection-tree node; expected latencies follow LZA_EARLY_EXIT_EN when defined.
module tb_lza_dt_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_n_pos, in_z_pos, in_p_pos;
    logic        chunk_valid;
    logic [7:0]  chunk_n_pos, chunk_z_pos, chunk_p_pos;
    logic        tree_Z, tree_P, tree_N, tree_Y;
    logic        out_valid, out_ready;
    logic        out_Z, out_P, out_N, out_Y;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lza_dt_seq_ctrl #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_n_pos(in_n_pos), .in_z_pos(in_z_pos), .in_p_pos(in_p_pos),
        .chunk_valid(chunk_valid),
        .chunk_n_pos(chunk_n_pos), .chunk_z_pos(chunk_z_pos), .chunk_p_pos(chunk_p_pos),
        .tree_Z(tree_Z), .tree_P(tree_P), .tree_N(tree_N), .tree_Y(tree_Y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_Z(out_Z), .out_P(out_P), .out_N(out_N), .out_Y(out_Y)
    );

    // Tree node: classify the chunk by its first two non-z positions, MSB first.
    function automatic logic [3:0] tree_node(input logic [7:0] n, input logic [7:0] z,
                                             input logic [7:0] p);
        int first  = -1;
        int second = -1;
        for (int i = 7; i >= 0; i--) begin
            if (!z[i]) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        if (first < 0) return 4'b1000;
        if (n[first]) return 4'b0010;
        if (second < 0) return 4'b0100;
        if (n[second]) return 4'b0001;
        return 4'b0000;
    endfunction

    assign {tree_Z, tree_P, tree_N, tree_Y} = tree_node(chunk_n_pos, chunk_z_pos, chunk_p_pos);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] n, z, p;
        logic [3:0]  flags;   // {Z,P,N,Y}
        int          lat;     // edges from accept to out_valid
    } vec_t;

    vec_t vecs[5];

    // Accept one triple, check first chunk and latency, leave the bench #1 after the edge
    // that raised out_valid (or after the timeout).
    task automatic start_and_wait(input vec_t v);
        int lat;
        @(negedge clk);
        check({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_n_pos = v.n;
        in_z_pos = v.z;
        in_p_pos = v.p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_n_pos = ~v.n;
        in_z_pos = ~v.z;
        in_p_pos = ~v.p;
        check({v.name, "_chunk_valid"}, {31'd0, chunk_valid}, 32'd1);
        check({v.name, "_busy"}, {31'd0, in_ready}, 32'd0);
        check({v.name, "_chunk0"}, {8'd0, chunk_n_pos, chunk_z_pos, chunk_p_pos},
              {8'd0, v.n[31:24], v.z[31:24], v.p[31:24]});
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({v.name, "_latency"}, lat, v.lat);
        check({v.name, "_flags"}, {28'd0, out_Z, out_P, out_N, out_Y}, {28'd0, v.flags});
        check({v.name, "_done_chunk_valid"}, {31'd0, chunk_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        start_and_wait(v);
        @(posedge clk);
        #1;
        check({v.name, "_back_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        vecs[0] = '{"all_z", 32'h0, 32'hFFFFFFFF, 32'h0, 4'b1000, 4};
        vecs[1] = '{"lone_p", 32'h0, ~32'h00000020, 32'h00000020, 4'b0100, 4};
`ifdef LZA_EARLY_EXIT_EN
        vecs[2] = '{"n30", 32'h40000000, ~32'h40000000, 32'h0, 4'b0010, 1};
        vecs[3] = '{"p20_n12", 32'h00001000, ~32'h00101000, 32'h00100000, 4'b0001, 3};
        vecs[4] = '{"p_then_p", 32'h0, ~32'h00810000, 32'h00810000, 4'b0000, 2};
`else
        vecs[2] = '{"n30", 32'h40000000, ~32'h40000000, 32'h0, 4'b0010, 4};
        vecs[3] = '{"p20_n12", 32'h00001000, ~32'h00101000, 32'h00100000, 4'b0001, 4};
        vecs[4] = '{"p_then_p", 32'h0, ~32'h00810000, 32'h00810000, 4'b0000, 4};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_n_pos  = '0;
        in_z_pos  = '0;
        in_p_pos  = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valids", {30'd0, chunk_valid, out_valid}, 32'd0);
        check("rst_out_flags", {28'd0, out_Z, out_P, out_N, out_Y}, 32'd0);
        check("rst_chunks", {8'd0, chunk_n_pos, chunk_z_pos, chunk_p_pos}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure: result held for 10 cycles, in_valid ignored meanwhile.
        out_ready = 1'b0;
        start_and_wait(vecs[3]);
        in_valid = 1'b1;
        in_z_pos = 32'hFFFFFFFF;
        in_n_pos = '0;
        in_p_pos = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {26'd0, out_valid, in_ready, out_Z, out_P, out_N, out_Y},
                  {26'd0, 2'b10, 4'b0001});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

        // Reset while chunk 2 is on the tree, then a clean transaction.
        @(negedge clk);
        in_n_pos = vecs[1].n;
        in_z_pos = vecs[1].z;
        in_p_pos = vecs[1].p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_chunk2", {24'd0, chunk_z_pos}, {24'd0, vecs[1].z[15:8]});
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_run", {29'd0, chunk_valid, out_valid, in_ready}, 32'b001);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[3]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
